// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute sequencer and the combinational ALU.
//   - RISC-V major opcodes handled by the sequencer (OP_R, OP_IMM)
//   - funct3 / funct7 field values
//   - alu_op_t : 4-bit ALU operation code (ADD is 0 so an idle bus reads as
//                "ADD of zeros")
//   - seq_state_t : sequencer FSM states
// Optional feature macro used by clients: ALU_SEQ_MUL_EN
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
// Combinational decoder for the execute sequencer. Recognises the base R-type
// ALU group and ADDI; every other encoding is reported as not legal.
// Optional feature macro: ALU_SEQ_MUL_EN (funct7=0000001, funct3=000 -> MUL).
//
// Ports
//   i_instr     in  32    instruction word
//   o_legal     out 1     encoding is one the sequencer executes
//   o_alu_op    out 4     ALU operation for the EXEC cycle
//   o_use_imm   out 1     operand B is the immediate instead of rs2 data
//   o_imm       out XLEN  sign-extended I-type immediate
//   o_rs1/rs2   out 5     source register fields
//   o_rd        out 5     destination register field
// -----------------------------------------------------------------------------
module alu_seq_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic            o_legal,
  output alu_op_t         o_alu_op,
  output logic            o_use_imm,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign o_rd  = i_instr[11:7];
  assign o_rs1 = i_instr[19:15];
  assign o_rs2 = i_instr[24:20];
  assign o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};

  always_comb begin
    o_legal   = 1'b0;
    o_alu_op  = ALU_ADD;
    o_use_imm = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_funct7 == F7_BASE) begin
          // Every funct3 has a base-group meaning when funct7 is zero.
          o_legal = 1'b1;
          case (w_funct3)
            F3_ADD_SUB: o_alu_op = ALU_ADD;
            F3_SLL:     o_alu_op = ALU_SLL;
            F3_SLT:     o_alu_op = ALU_SLT;
            F3_SLTU:    o_alu_op = ALU_SLTU;
            F3_XOR:     o_alu_op = ALU_XOR;
            F3_SRL_SRA: o_alu_op = ALU_SRL;
            F3_OR:      o_alu_op = ALU_OR;
            F3_AND:     o_alu_op = ALU_AND;
            default:    o_alu_op = ALU_ADD;
          endcase
        end else if (w_funct7 == F7_ALT) begin
          // Alternate funct7 only modifies ADD and SRL.
          if (w_funct3 == F3_ADD_SUB) begin
            o_legal  = 1'b1;
            o_alu_op = ALU_SUB;
          end else if (w_funct3 == F3_SRL_SRA) begin
            o_legal  = 1'b1;
            o_alu_op = ALU_SRA;
          end
        end else if (w_funct7 == F7_MULDIV) begin
`ifdef ALU_SEQ_MUL_EN
          if (w_funct3 == F3_ADD_SUB) begin
            o_legal  = 1'b1;
            o_alu_op = ALU_MUL;
          end
`endif
        end
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADD_SUB) begin
          o_legal   = 1'b1;
          o_alu_op  = ALU_ADD;
          o_use_imm = 1'b1;
        end
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Four-cycle execute sequencer: IDLE -> READ -> EXEC -> WB -> IDLE.
// Accepts one instruction over valid/ready, reads rs1/rs2 from a register file
// with one cycle of read latency, drives the external combinational ALU during
// EXEC only, captures the result and issues one write-back strobe.
// Optional feature macro: ALU_SEQ_MUL_EN (enables MUL decode in alu_seq_decode).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr        instruction offer
//   instr_ready              high in IDLE only
//   rf_raddr1/rf_raddr2      register read addresses (READ state)
//   rf_rdata1/rf_rdata2      register read data (valid in EXEC)
//   alu_op/alu_a/alu_b       ALU controls, zero outside EXEC
//   alu_result               combinational ALU result
//   wb_valid/wb_rd/wb_data   write-back (WB state, suppressed for rd=0)
//   illegal                  one-cycle pulse after accepting a bad encoding
//   busy                     state is not IDLE
// -----------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  output logic                 instr_ready,
  output logic [RF_ADDR_W-1:0] rf_raddr1,
  output logic [RF_ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output alu_op_t              alu_op,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 wb_valid,
  output logic [RF_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 illegal,
  output logic                 busy
);

  seq_state_t      r_state;
  seq_state_t      w_state_next;

  logic            w_dec_legal;
  alu_op_t         w_dec_op;
  logic            w_dec_use_imm;
  logic [XLEN-1:0] w_dec_imm;
  logic [4:0]      w_dec_rs1;
  logic [4:0]      w_dec_rs2;
  logic [4:0]      w_dec_rd;

  // Decoded fields of the accepted instruction; they carry everything the
  // later states need, so the raw word itself is not kept.
  alu_op_t         r_op;
  logic            r_use_imm;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  logic            w_accept;

  alu_seq_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_instr  (instr),
    .o_legal  (w_dec_legal),
    .o_alu_op (w_dec_op),
    .o_use_imm(w_dec_use_imm),
    .o_imm    (w_dec_imm),
    .o_rs1    (w_dec_rs1),
    .o_rs2    (w_dec_rs2),
    .o_rd     (w_dec_rd)
  );

  // Uses the state register directly so ready never depends on valid.
  assign w_accept = instr_valid && (r_state == ST_IDLE);
  assign illegal  = r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= ALU_ADD;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_accept && !w_dec_legal;
      if (w_accept && w_dec_legal) begin
        r_op      <= w_dec_op;
        r_use_imm <= w_dec_use_imm;
        r_imm     <= w_dec_imm;
        r_rs1     <= w_dec_rs1;
        r_rs2     <= w_dec_rs2;
        r_rd      <= w_dec_rd;
      end
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    busy         = 1'b1;
    rf_raddr1    = '0;
    rf_raddr2    = '0;
    alu_op       = ALU_ADD;
    alu_a        = '0;
    alu_b        = '0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        // An illegal word is consumed here but never leaves IDLE.
        if (w_accept && w_dec_legal) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        rf_raddr1    = RF_ADDR_W'(r_rs1);
        rf_raddr2    = RF_ADDR_W'(r_rs2);
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op       = r_op;
        alu_a        = rf_rdata1;
        alu_b        = r_use_imm ? r_imm : rf_rdata2;
        w_state_next = ST_WB;
      end
      ST_WB: begin
        // x0 is hard-wired zero, so a write to it is simply not issued.
        wb_valid     = (r_rd != 5'd0);
        wb_rd        = RF_ADDR_W'(r_rd);
        wb_data      = r_result;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule
